tod_counter: RTL and testbench
==============================

# tod_counter

Time-of-day keeper that consumes the one-cycle seconds pulse produced by the alarm clock's tick generator and maintains a 24-hour HH:MM:SS count in packed BCD. Sits between the seconds tick generator and the display/alarm logic. Provides:
- manual time-set mode;
- carry pulses for downstream consumers;
- a registered alarm-match pulse.

## Interface
Parameters:
- RESET_HH, 8'h00: BCD hours loaded on reset (must be 00–23).
- RESET_MM, 8'h00: BCD minutes loaded on reset (must be 00–59).

Ports:
- clk  input  1  system clock, single domain.
- reset_sync  input  1  synchronous reset, active-high.
- sec_inc  input  1  one-cycle seconds pulse from the tick generator.
- set_en  input  1  level; high = time-set mode, time frozen.
- set_field  input  2  field select: 2'd0 sec, 2'd1 min, 2'd2 hour, 2'd3 none.
- set_up  input  1  one-cycle pulse; increments the selected field.
- alarm_en  input  1  level; enables alarm matching.
- alarm_hh  input  8  BCD alarm hours.
- alarm_mm  input  8  BCD alarm minutes.
- hours  output  8  BCD hours 00–23.
- mins  output  8  BCD minutes 00–59.
- secs  output  8  BCD seconds 00–59.
- min_tick  output  1  one-cycle pulse on a seconds wrap 59→00.
- hour_tick  output  1  one-cycle pulse on a minutes wrap 59→00 caused by a carry.
- day_tick  output  1  one-cycle pulse on 23:59:59→00:00:00.
- alarm_fire  output  1  one-cycle alarm-match pulse.

## Operation
- Reset: hours=RESET_HH, mins=RESET_MM, secs=00. All tick outputs and alarm_fire are 0. Reset overrides every other input in the same cycle.
- Run mode (set_en=0):
  - On each sec_inc, secs increments in BCD: low digit 9→0 carries to the high digit.
  - secs 59→00 carries into mins; mins 59→00 carries into hours; hours 23→00.
  - All carries resolve in the same clock edge, e.g. 23:59:59 + sec_inc → 00:00:00 in one cycle.
  - set_up is ignored.
- Set mode (set_en=1):
  - sec_inc is ignored and dropped, not queued.
  - set_up increments only the field chosen by set_field, wrapping within that field: secs/mins 59→00, hours 23→00.
  - No carry into adjacent fields. No tick outputs. No alarm_fire.
  - set_field=3 makes set_up a no-op.
- Mode switch: set_en may toggle on any cycle. A sec_inc in the same cycle as set_en=1 is dropped. On leaving set mode, counting resumes with the next sec_inc; the fractional second is not restarted.
- Ticks:
  - min_tick, hour_tick and day_tick are registered and high in the same cycle the wrapped value appears on the outputs.
  - A day rollover asserts min_tick, hour_tick and day_tick together.
- Alarm:
  - alarm_fire=1 for one cycle when a run-mode sec_inc produces secs=00 with hours==alarm_hh, mins==alarm_mm and alarm_en=1, all sampled on that edge.
  - Fires at most once per matching minute.
  - Out-of-range alarm values never match. No fire on reset or set operations.
  - alarm_en low suppresses the fire but not the counting.
- Output values are always valid BCD. Internal state never holds an illegal digit.

## Timing
- Latency: sec_inc or set_up sampled at edge N → updated outputs and pulses visible after edge N.
- Minimum input spacing: one cycle. sec_inc on consecutive cycles must give consecutive increments.
- All outputs come from flops; there is no combinational path from inputs to outputs.

## Structure
- Shared package alarm_clock_pkg holds:
  - the set_field encoding as an enum: FIELD_SEC, FIELD_MIN, FIELD_HOUR, FIELD_NONE;
  - BCD limit constants SEC_MAX=8'h59, MIN_MAX=8'h59, HOUR_MAX=8'h23.
- Sub-module bcd_mod_counter:
  - implements a two-digit BCD counter with parameter MAX, inputs inc and clr, registered outputs value and wrap;
  - instantiated three times, once each for secs, mins and hours.
- Top level contains the mode muxing, carry chaining, and the alarm compare flop.

## Test plan
- Reset with RESET_HH=8'h07, RESET_MM=8'h30, then 61 sec_inc pulses → 07:31:01. min_tick seen exactly once, the cycle after pulse 60.
- Preload 23:59:58 via set mode, then 2 sec_inc → 23:59:59 then 00:00:00. min_tick, hour_tick and day_tick all high in the single cycle after the second pulse.
- set_en=1, set_field=hour, 25 set_up pulses from 00 → hours=01, mins and secs unchanged, no ticks. 10 sec_inc in set mode → secs unchanged.
- alarm_hh=8'h06, alarm_mm=8'h45, alarm_en=1, time 06:44:59, sec_inc → alarm_fire one cycle with outputs 06:45:00. 60 more pulses → no second fire. Repeat with alarm_en=0 → no fire.
- Assert reset_sync in the same cycle as sec_inc at 12:59:59 → outputs reset values, no ticks, no alarm_fire.
- sec_inc high for 3 consecutive cycles from 00:00:58 → 00:00:59, 00:01:00, 00:01:01. min_tick high only in the second cycle.

Source files
------------

// File: rtl/alarm_clock_pkg.sv
// Shared definitions for the alarm clock: set-field encoding and BCD limits.
package alarm_clock_pkg;

    typedef enum logic [1:0] {
        FIELD_SEC  = 2'd0,
        FIELD_MIN  = 2'd1,
        FIELD_HOUR = 2'd2,
        FIELD_NONE = 2'd3
    } set_field_e;

    localparam logic [7:0] SEC_MAX  = 8'h59;
    localparam logic [7:0] MIN_MAX  = 8'h59;
    localparam logic [7:0] HOUR_MAX = 8'h23;

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit packed-BCD counter that wraps MAX -> 00.
// next_o exposes the value the counter will take on this edge so the
// parent can compare against it without waiting a cycle.
module bcd_mod_counter #(
    parameter logic [7:0] MAX       = 8'h59,
    parameter logic [7:0] RESET_VAL = 8'h00
) (
    input  logic       clk_i,
    input  logic       clr_i,
    input  logic       inc_i,
    output logic [7:0] value_o,
    output logic [7:0] next_o,
    output logic       wrap_o
);

    logic [7:0] value_q, value_d;
    logic       wrap_q,  wrap_d;

    // BCD increment: MAX wraps to 00, a low digit of 9 carries into the high digit
    always_comb begin
        value_d = value_q;
        wrap_d  = 1'b0;
        if (inc_i) begin
            if (value_q == MAX) begin
                value_d = 8'h00;
                wrap_d  = 1'b1;
            end else if (value_q[3:0] == 4'd9) begin
                value_d = {value_q[7:4] + 4'd1, 4'd0};
            end else begin
                value_d = {value_q[7:4], value_q[3:0] + 4'd1};
            end
        end
    end

    // Value and wrap flag registered together so the wrap lines up with 00
    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            value_q <= RESET_VAL;
            wrap_q  <= 1'b0;
        end else begin
            value_q <= value_d;
            wrap_q  <= wrap_d;
        end
    end

    assign value_o = value_q;
    assign next_o  = value_d;
    assign wrap_o  = wrap_q;

endmodule

// File: rtl/tod_counter.sv
// 24-hour HH:MM:SS time-of-day keeper in packed BCD with a time-set mode,
// carry pulses for downstream logic and a registered alarm-match pulse.
module tod_counter
    import alarm_clock_pkg::*;
#(
    parameter logic [7:0] RESET_HH = 8'h00,
    parameter logic [7:0] RESET_MM = 8'h00
) (
    input  logic       clk,
    input  logic       reset_sync,
    input  logic       sec_inc,
    input  logic       set_en,
    input  logic [1:0] set_field,
    input  logic       set_up,
    input  logic       alarm_en,
    input  logic [7:0] alarm_hh,
    input  logic [7:0] alarm_mm,
    output logic [7:0] hours,
    output logic [7:0] mins,
    output logic [7:0] secs,
    output logic       min_tick,
    output logic       hour_tick,
    output logic       day_tick,
    output logic       alarm_fire
);

    set_field_e fld;
    logic       run_inc;
    logic       sec_en, min_en, hour_en;
    logic [7:0] sec_nxt, min_nxt, hour_nxt;
    logic       sec_wrap, min_wrap, hour_wrap;
    logic       run_q;
    logic       alarm_q;

    assign fld     = set_field_e'(set_field);
    // sec_inc is dropped entirely while set_en is high
    assign run_inc = sec_inc & ~set_en;

    // Mode mux: set mode bumps one field with no carry, run mode chains carries
    always_comb begin
        sec_en  = 1'b0;
        min_en  = 1'b0;
        hour_en = 1'b0;
        if (set_en) begin
            sec_en  = set_up && (fld == FIELD_SEC);
            min_en  = set_up && (fld == FIELD_MIN);
            hour_en = set_up && (fld == FIELD_HOUR);
        end else begin
            sec_en  = sec_inc;
            min_en  = sec_inc && (secs == SEC_MAX);
            hour_en = sec_inc && (secs == SEC_MAX) && (mins == MIN_MAX);
        end
    end

    bcd_mod_counter #(.MAX(SEC_MAX), .RESET_VAL(8'h00)) u_sec (
        .clk_i(clk), .clr_i(reset_sync), .inc_i(sec_en),
        .value_o(secs), .next_o(sec_nxt), .wrap_o(sec_wrap)
    );

    bcd_mod_counter #(.MAX(MIN_MAX), .RESET_VAL(RESET_MM)) u_min (
        .clk_i(clk), .clr_i(reset_sync), .inc_i(min_en),
        .value_o(mins), .next_o(min_nxt), .wrap_o(min_wrap)
    );

    bcd_mod_counter #(.MAX(HOUR_MAX), .RESET_VAL(RESET_HH)) u_hour (
        .clk_i(clk), .clr_i(reset_sync), .inc_i(hour_en),
        .value_o(hours), .next_o(hour_nxt), .wrap_o(hour_wrap)
    );

    // Run-mode qualifier for the wrap flags, plus the alarm compare on the post-edge time
    always_ff @(posedge clk) begin
        if (reset_sync) begin
            run_q   <= 1'b0;
            alarm_q <= 1'b0;
        end else begin
            run_q   <= run_inc;
            alarm_q <= run_inc && alarm_en && (sec_nxt == 8'h00) &&
                       (hour_nxt == alarm_hh) && (min_nxt == alarm_mm);
        end
    end

    // Wraps caused by set_up are masked; only run-mode carries produce ticks
    assign min_tick   = sec_wrap  & run_q;
    assign hour_tick  = min_wrap  & run_q;
    assign day_tick   = hour_wrap & run_q;
    assign alarm_fire = alarm_q;

endmodule

// File: tb/tb_tod_counter.sv
// Bench for tod_counter: directed scenarios plus a randomized run, all checked
// against a model that tracks time as plain seconds-since-midnight.
module tb_tod_counter;

    logic       clk = 1'b0;
    logic       reset_sync = 1'b1;
    logic       sec_inc = 1'b0;
    logic       set_en = 1'b0;
    logic [1:0] set_field = 2'd3;
    logic       set_up = 1'b0;
    logic       alarm_en = 1'b0;
    logic [7:0] alarm_hh = 8'h00;
    logic [7:0] alarm_mm = 8'h00;
    logic [7:0] hours, mins, secs;
    logic       min_tick, hour_tick, day_tick, alarm_fire;

    int total = 0;
    int bad   = 0;

    // reference model state
    int   mh = 7, mm = 30, ms = 0;
    bit   emin, ehour, eday, efire;
    bit   al_en = 1'b0;
    logic [7:0] ahh = 8'h00, amm = 8'h00;

    tod_counter #(.RESET_HH(8'h07), .RESET_MM(8'h30)) dut (
        .clk(clk), .reset_sync(reset_sync), .sec_inc(sec_inc), .set_en(set_en),
        .set_field(set_field), .set_up(set_up), .alarm_en(alarm_en),
        .alarm_hh(alarm_hh), .alarm_mm(alarm_mm), .hours(hours), .mins(mins),
        .secs(secs), .min_tick(min_tick), .hour_tick(hour_tick),
        .day_tick(day_tick), .alarm_fire(alarm_fire)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] bcd(input int v);
        return 8'(((v / 10) * 16) + (v % 10));
    endfunction

    function automatic logic [23:0] exp_time();
        return {bcd(mh), bcd(mm), bcd(ms)};
    endfunction

    // Drive one cycle of inputs, advance the model, then step past the edge
    task automatic cycle(input bit rst, input bit sec, input bit sen, input int fld, input bit up);
        int t;
        reset_sync = rst; sec_inc = sec; set_en = sen; set_field = 2'(fld); set_up = up;
        alarm_en = al_en; alarm_hh = ahh; alarm_mm = amm;
        emin = 0; ehour = 0; eday = 0; efire = 0;
        if (rst) begin
            mh = 7; mm = 30; ms = 0;
        end else if (sen) begin
            if (up) begin
                case (fld)
                    0: ms = (ms + 1) % 60;
                    1: mm = (mm + 1) % 60;
                    2: mh = (mh + 1) % 24;
                    default: ;
                endcase
            end
        end else if (sec) begin
            t = (mh * 3600 + mm * 60 + ms + 1) % 86400;
            mh = t / 3600; mm = (t / 60) % 60; ms = t % 60;
            emin  = (ms == 0);
            ehour = (t % 3600 == 0);
            eday  = (t == 0);
            efire = al_en && (ms == 0) && (bcd(mh) == ahh) && (bcd(mm) == amm);
        end
        @(posedge clk);
        #1;
    endtask

    // Load a time through set-mode pulses, then drop back to run mode
    task automatic set_time(input int h, input int m, input int s);
        int n;
        n = (s - ms + 60) % 60; repeat (n) cycle(0, 0, 1, 0, 1);
        n = (m - mm + 60) % 60; repeat (n) cycle(0, 0, 1, 1, 1);
        n = (h - mh + 24) % 24; repeat (n) cycle(0, 0, 1, 2, 1);
        cycle(0, 0, 0, 3, 0);
    endtask

    task automatic test_reset();
        cycle(1, 0, 0, 3, 0);
        cycle(1, 1, 0, 3, 0);
        total++;
        if ({hours, mins, secs} !== 24'h073000) begin
            bad++; $display("FAIL reset_time got %h exp 073000", {hours, mins, secs});
        end
        total++;
        if ({min_tick, hour_tick, day_tick, alarm_fire} !== 4'b0) begin
            bad++; $display("FAIL reset_ticks got %b exp 0000", {min_tick, hour_tick, day_tick, alarm_fire});
        end
    endtask

    task automatic test_count61();
        int nmin = 0;
        int at = -1;
        for (int i = 1; i <= 61; i++) begin
            cycle(0, 1, 0, 3, 0);
            if (min_tick === 1'b1) begin nmin++; at = i; end
        end
        total++;
        if ({hours, mins, secs} !== 24'h073101) begin
            bad++; $display("FAIL count61_time got %h exp 073101", {hours, mins, secs});
        end
        total++;
        if (nmin != 1 || at != 60) begin
            bad++; $display("FAIL count61_min_tick got count=%0d at=%0d exp count=1 at=60", nmin, at);
        end
    endtask

    task automatic test_rollover();
        set_time(23, 59, 58);
        cycle(0, 1, 0, 3, 0);
        total++;
        if ({hours, mins, secs, min_tick, hour_tick, day_tick} !== {24'h235959, 3'b000}) begin
            bad++; $display("FAIL roll_first got %h/%b exp 235959/000", {hours, mins, secs}, {min_tick, hour_tick, day_tick});
        end
        cycle(0, 1, 0, 3, 0);
        total++;
        if ({hours, mins, secs, min_tick, hour_tick, day_tick} !== {24'h000000, 3'b111}) begin
            bad++; $display("FAIL roll_day got %h/%b exp 000000/111", {hours, mins, secs}, {min_tick, hour_tick, day_tick});
        end
        cycle(0, 0, 0, 3, 0);
        total++;
        if ({min_tick, hour_tick, day_tick} !== 3'b000) begin
            bad++; $display("FAIL roll_pulse_len got %b exp 000", {min_tick, hour_tick, day_tick});
        end
    endtask

    task automatic test_set_hour();
        int nt = 0;
        set_time(0, 0, 0);
        for (int i = 0; i < 25; i++) begin
            cycle(0, 0, 1, 2, 1);
            if ({min_tick, hour_tick, day_tick, alarm_fire} !== 4'b0) nt++;
        end
        total++;
        if ({hours, mins, secs} !== 24'h010000 || nt != 0) begin
            bad++; $display("FAIL set_hour got %h ticks=%0d exp 010000 ticks=0", {hours, mins, secs}, nt);
        end
        repeat (10) cycle(0, 1, 1, 3, 0);
        total++;
        if ({hours, mins, secs} !== 24'h010000) begin
            bad++; $display("FAIL set_drop_sec got %h exp 010000", {hours, mins, secs});
        end
        cycle(0, 0, 0, 3, 0);
    endtask

    task automatic test_alarm();
        int nf = 0;
        al_en = 1; ahh = 8'h06; amm = 8'h45;
        set_time(6, 44, 59);
        cycle(0, 1, 0, 3, 0);
        total++;
        if ({hours, mins, secs, alarm_fire} !== {24'h064500, 1'b1}) begin
            bad++; $display("FAIL alarm_fire got %h/%b exp 064500/1", {hours, mins, secs}, alarm_fire);
        end
        repeat (60) begin
            cycle(0, 1, 0, 3, 0);
            if (alarm_fire === 1'b1) nf++;
        end
        total++;
        if (nf != 0 || {hours, mins, secs} !== 24'h064600) begin
            bad++; $display("FAIL alarm_once got fires=%0d time=%h exp 0 064600", nf, {hours, mins, secs});
        end
        al_en = 0;
        set_time(6, 44, 59);
        cycle(0, 1, 0, 3, 0);
        total++;
        if ({hours, mins, secs, alarm_fire} !== {24'h064500, 1'b0}) begin
            bad++; $display("FAIL alarm_disabled got %h/%b exp 064500/0", {hours, mins, secs}, alarm_fire);
        end
    endtask

    task automatic test_reset_priority();
        al_en = 1; ahh = 8'h07; amm = 8'h30;
        set_time(12, 59, 59);
        cycle(1, 1, 0, 3, 0);
        total++;
        if ({hours, mins, secs} !== 24'h073000 ||
            {min_tick, hour_tick, day_tick, alarm_fire} !== 4'b0) begin
            bad++; $display("FAIL reset_prio got %h/%b exp 073000/0000", {hours, mins, secs},
                            {min_tick, hour_tick, day_tick, alarm_fire});
        end
        al_en = 0;
        cycle(0, 0, 0, 3, 0);
    endtask

    task automatic test_back_to_back();
        logic [23:0] et [3];
        logic        em [3];
        et[0] = 24'h000059; et[1] = 24'h000100; et[2] = 24'h000101;
        em[0] = 1'b0;       em[1] = 1'b1;       em[2] = 1'b0;
        set_time(0, 0, 58);
        for (int i = 0; i < 3; i++) begin
            cycle(0, 1, 0, 3, 0);
            total++;
            if ({hours, mins, secs} !== et[i] || min_tick !== em[i]) begin
                bad++; $display("FAIL b2b_%0d got %h/%b exp %h/%b", i, {hours, mins, secs}, min_tick, et[i], em[i]);
            end
        end
    endtask

    task automatic test_random();
        int t;
        for (int blk = 0; blk < 8; blk++) begin
            set_time(int'($urandom % 24), int'($urandom % 60), 50 + int'($urandom % 10));
            t = (mh * 60 + mm + 1) % 1440;
            al_en = $urandom % 4 != 0;
            case ($urandom % 3)
                0: begin ahh = bcd(t / 60); amm = bcd(t % 60); end
                1: begin ahh = bcd(t / 60); amm = 8'h6A; end
                default: begin ahh = 8'($urandom); amm = 8'($urandom); end
            endcase
            for (int i = 0; i < 50; i++) begin
                cycle($urandom % 200 == 0, 1'($urandom % 3 != 0), $urandom % 6 == 0,
                      int'($urandom % 4), 1'($urandom));
                total++;
                if ({hours, mins, secs} !== exp_time() ||
                    {min_tick, hour_tick, day_tick, alarm_fire} !== {emin, ehour, eday, efire}) begin
                    bad++; $display("FAIL rand_%0d_%0d got %h/%b exp %h/%b", blk, i, {hours, mins, secs},
                                    {min_tick, hour_tick, day_tick, alarm_fire}, exp_time(),
                                    {emin, ehour, eday, efire});
                end
            end
        end
        al_en = 0;
    endtask

    initial begin
        test_reset();
        test_count61();
        test_rollover();
        test_set_hour();
        test_alarm();
        test_reset_priority();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
